regfile_arbiter: RTL and testbench

Two-port arbitrated front end for a 4 x 8-bit register file. Two independent requesters issue single read or write transactions through a req/ack handshake; the block picks one winner per transaction with round-robin priority, performs the access on internal register storage, and returns read data. It sits between the datapath sequencers and the register file, so the storage is never driven by two sources at once.

---
 rtl/regfile_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin front end for a small register file.
// Each transaction is IDLE (grant) -> ACCESS (storage op) -> ACK (one-cycle pulse).
module regfile_arbiter #(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [1:0]    addr0,
  input  logic [1:0]    addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [1:0]    addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];
  logic          winner;

  // A lone requester always wins; under contention the pointer decides.
  assign winner = (req0 && req1) ? prio_q : req1;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    mem_d    = mem_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = winner;
          prio_d  = ~winner;
          we_d    = winner ? we1    : we0;
          addr_d  = winner ? addr1  : addr0;
          wdata_d = winner ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          mem_d[addr_q] = wdata_q;
        end else if (gnt_q) begin
          rdata1_d = mem_q[addr_q];
        end else begin
          rdata0_d = mem_q[addr_q];
        end
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != IDLE);
  assign gnt_id = gnt_q;

  // Acks are mutually exclusive and only ever coincide with the ACK state.
  a_ack_onehot : assert property (@(posedge clk) disable iff (reset) !(ack0_q && ack1_q));
  a_ack_state  : assert property (@(posedge clk) disable iff (reset)
                                  (ack0_q || ack1_q) |-> (state_q == ACK));

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized and directed checks of regfile_arbiter against a transaction-level model
// (register array, per-port read results, alternating priority bit, fixed 3-cycle timing).
module tb_regfile_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [1:0]    addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy, gnt_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] exp_mem [4];
  logic [DW-1:0] exp_rd [2];
  logic          exp_prio;

  regfile_arbiter #(.DW(DW), .NREG(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_prio  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check("rst_ack",    {ack1, ack0}, 2'b00);
    check("rst_busy",   busy, 1'b0);
    check("rst_gnt",    gnt_id, 1'b0);
    check("rst_rdata0", rdata0, '0);
    check("rst_rdata1", rdata1, '0);
    reset = 1'b0;
  endtask

  task automatic set0(input logic w, input logic [1:0] a, input logic [DW-1:0] d);
    we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic w, input logic [1:0] a, input logic [DW-1:0] d);
    we1 = w; addr1 = a; wdata1 = d;
  endtask

  // Called at a negedge just before the grant edge; returns at the negedge after ACK.
  task automatic serve_one(input int p, input bit hold);
    logic          w;
    logic [1:0]    a;
    logic [DW-1:0] d;
    w = (p == 1) ? we1 : we0;
    a = (p == 1) ? addr1 : addr0;
    d = (p == 1) ? wdata1 : wdata0;
    @(negedge clk);
    check("grant_busy", busy, 1'b1);
    check("grant_id",   gnt_id, p[0]);
    check("grant_noack", {ack1, ack0}, 2'b00);
    if (w) exp_mem[a] = d;
    else   exp_rd[p] = exp_mem[a];
    exp_prio = ~p[0];
    @(negedge clk);
    check("ack_pulse", {ack1, ack0}, (p == 1) ? 2'b10 : 2'b01);
    check("ack_busy",  busy, 1'b1);
    check("rdata0",    rdata0, exp_rd[0]);
    check("rdata1",    rdata1, exp_rd[1]);
    if (!hold) begin
      if (p == 1) req1 = 1'b0;
      else        req0 = 1'b0;
    end
    @(negedge clk);
    check("post_ack", {ack1, ack0}, 2'b00);
    check("idle_busy", busy, 1'b0);
  endtask

  // One arbitration round: raise the chosen reqs and serve every requester.
  task automatic do_round(input bit r0, input bit r1, input bit mutate);
    int first;
    req0 = r0;
    req1 = r1;
    if (!r0 && !r1) begin
      @(negedge clk);
      check("quiet_busy", busy, 1'b0);
      check("quiet_ack", {ack1, ack0}, 2'b00);
      return;
    end
    first = (r0 && r1) ? int'(exp_prio) : (r1 ? 1 : 0);
    serve_one(first, 1'b0);
    if (r0 && r1) begin
      if (mutate) begin
        if (first == 0) set1($urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom));
        else            set0($urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom));
      end
      serve_one(1 - first, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    set0(1'b0, 2'd0, '0);
    set1(1'b0, 2'd0, '0);

    // Reset, then read every register from port 0
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set0(1'b0, 2'(i), 8'hEE);
      do_round(1'b1, 1'b0, 1'b0);
      check("reset_reg_val", rdata0, 8'h00);
    end

    // Write/read round trip across ports
    set0(1'b1, 2'd2, 8'hA5);
    do_round(1'b1, 1'b0, 1'b0);
    set1(1'b0, 2'd2, 8'h00);
    do_round(1'b0, 1'b1, 1'b0);
    check("rt_rdata1", rdata1, 8'hA5);

    // Simultaneous writes to reg1 after reset: port 0 first, port 1 last
    apply_reset();
    set0(1'b1, 2'd1, 8'h11);
    set1(1'b1, 2'd1, 8'h22);
    do_round(1'b1, 1'b1, 1'b0);
    set0(1'b0, 2'd1, 8'h00);
    do_round(1'b1, 1'b0, 1'b0);
    check("sim_final", rdata0, 8'h22);

    // Sustained contention: both reqs held, six grants must alternate 0,1,0,1,0,1
    apply_reset();
    set0(1'b1, 2'd3, 8'h5A);
    set1(1'b0, 2'd3, 8'h00);
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("rr_expect", {31'd0, exp_prio}, 32'(i % 2));
      serve_one(int'(exp_prio), 1'b1);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset on the ACCESS edge cancels a pending write
    set0(1'b1, 2'd3, 8'h77);
    do_round(1'b1, 1'b0, 1'b0);
    set1(1'b1, 2'd3, 8'hFF);
    req1 = 1'b1;
    @(negedge clk);
    check("mid_grant", gnt_id, 1'b1);
    reset = 1'b1;
    req1 = 1'b0;
    @(negedge clk);
    model_reset();
    check("mid_noack", {ack1, ack0}, 2'b00);
    check("mid_busy",  busy, 1'b0);
    reset = 1'b0;
    set0(1'b0, 2'd3, 8'h00);
    set1(1'b0, 2'd0, 8'h00);
    do_round(1'b1, 1'b1, 1'b0);   // prio back at 0: port 0 wins first
    check("mid_reg3", rdata0, 8'h00);

    // Reset during ACK drops the ack at the next edge
    set0(1'b0, 2'd0, 8'h00);
    req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rack_ack", ack0, 1'b1);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    model_reset();
    check("rack_drop", {ack1, ack0}, 2'b00);
    check("rack_busy", busy, 1'b0);
    reset = 1'b0;

    // Long-held request: port 0 keeps req through its ack and is granted again
    set0(1'b1, 2'd0, 8'h01);
    req0 = 1'b1;
    serve_one(0, 1'b1);
    serve_one(0, 1'b0);
    set1(1'b0, 2'd0, 8'h00);
    do_round(1'b0, 1'b1, 1'b0);
    check("held_val", rdata1, 8'h01);

    // Randomized traffic, including loser fields changing before their grant
    for (int i = 0; i < 80; i++) begin
      set0($urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom));
      set1($urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom));
      do_round($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // Final sweep: every register readable and matching the model
    for (int i = 0; i < 4; i++) begin
      set1(1'b0, 2'(i), 8'h00);
      do_round(1'b0, 1'b1, 1'b0);
      check("sweep", rdata1, exp_mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
